// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display controller: animation modes,
// segment glyph encodings and the hex/spin glyph helpers.
package seg_pkg;

    typedef enum logic [1:0] {
        ANIM_STATIC = 2'd0,
        ANIM_BLINK  = 2'd1,
        ANIM_SPIN   = 2'd2,
        ANIM_COUNT  = 2'd3
    } anim_mode_t;

    // Segment bit order is {g,f,e,d,c,b,a}; spin walks a..f around the rim.
    localparam int         SPIN_STEPS = 6;
    localparam logic [6:0] SPIN_A     = 7'h01;
    localparam logic [6:0] SPIN_B     = 7'h02;
    localparam logic [6:0] SPIN_C     = 7'h04;
    localparam logic [6:0] SPIN_D     = 7'h08;
    localparam logic [6:0] SPIN_E     = 7'h10;
    localparam logic [6:0] SPIN_F     = 7'h20;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] spin_to_seg(input logic [2:0] step);
        logic [6:0] g;
        case (step)
            3'd0: g = SPIN_A;
            3'd1: g = SPIN_B;
            3'd2: g = SPIN_C;
            3'd3: g = SPIN_D;
            3'd4: g = SPIN_E;
            3'd5: g = SPIN_F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Register-side connection of the display controller: the three control
// fields coming in and the registered display outputs going out.
interface seg_display_ctrl_if;
    logic [3:0] duty;
    logic [3:0] disp_val;
    logic [1:0] anim;
    logic [6:0] seg_out;
    logic       dp_out;
    logic       tick_out;

    modport master (
        output duty, disp_val, anim,
        input  seg_out, dp_out, tick_out
    );

    modport slave (
        input  duty, disp_val, anim,
        output seg_out, dp_out, tick_out
    );
endinterface

// File: rtl/seg_pwm_dimmer.sv
// PWM brightness gate for the display. With BREATHE_EN defined the blink
// mode instead ramps an effective duty up and down once per animation tick.
module seg_pwm_dimmer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] duty,
    input  logic       tick,
    input  logic       restart,
    input  logic       breathe,
    output logic       pwm_on
);

    logic [3:0] pwm_cnt;
    logic [3:0] lvl;

    // NOTE: synchronous reset inside the clocked block, and only
    // non-blocking assignments for state so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

`ifdef BREATHE_EN
    logic [3:0] eff_duty;
    logic       dir_up;

    // A restarting mode sees level 0 immediately, matching the cleared ramp.
    assign lvl = breathe ? (restart ? 4'd0 : eff_duty) : duty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eff_duty <= 4'd0;
            dir_up   <= 1'b1;
        end else if (!breathe || restart) begin
            eff_duty <= 4'd0;
            dir_up   <= 1'b1;
        end else if (duty < eff_duty) begin
            eff_duty <= duty;
        end else if (tick) begin
            if (dir_up) begin
                if (eff_duty < duty) begin
                    eff_duty <= eff_duty + 4'd1;
                end else begin
                    dir_up   <= 1'b0;
                    eff_duty <= (eff_duty != 4'd0) ? eff_duty - 4'd1 : 4'd0;
                end
            end else if (eff_duty != 4'd0) begin
                eff_duty <= eff_duty - 4'd1;
            end else begin
                dir_up   <= 1'b1;
                eff_duty <= (duty != 4'd0) ? 4'd1 : 4'd0;
            end
        end
    end
`else
    logic unused_ramp_inputs;

    assign unused_ramp_inputs = ^{tick, restart, breathe};
    assign lvl = duty;
`endif

    // Full scale is forced on; otherwise on for lvl of every 16 cycles.
    assign pwm_on = (lvl == 4'hF) || (pwm_cnt < lvl);

endmodule

// File: rtl/seg_display_ctrl.sv
// Single-digit 7-segment driver: hex glyphs, four tick-paced animations and
// PWM dimming, all outputs registered. BREATHE_EN turns BLINK into breathe.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 1000000,
    parameter int TICK_W   = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_display_ctrl_if.slave  bus
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    anim_mode_t        mode;
    anim_mode_t        anim_q;
    logic [TICK_W-1:0] presc, presc_d;
    logic [2:0]        step, step_d;
    logic              phase, phase_d;
    logic [3:0]        count, count_d, count_e;
    logic [3:0]        disp_q;
    logic              hb;
    logic              restart, tick, reload, pwm_on;
    logic [6:0]        glyph;
    logic [6:0]        seg_q;
    logic              dp_q, tick_q;

    assign mode    = anim_mode_t'(bus.anim);
    assign restart = (mode != anim_q);
    assign tick    = !restart && (presc == TICK_LAST);
    assign reload  = restart || ((mode == ANIM_COUNT) && (bus.disp_val != disp_q));

    seg_pwm_dimmer u_dimmer (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (bus.duty),
        .tick    (tick),
        .restart (restart),
        .breathe (mode == ANIM_BLINK),
        .pwm_on  (pwm_on)
    );

    // NOTE: every always_comb output gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        presc_d = presc + 1'b1;
        step_d  = step;
        phase_d = phase;
        count_d = count;
        if (restart) begin
            presc_d = '0;
            step_d  = 3'd0;
            phase_d = 1'b0;
        end else if (tick) begin
            presc_d = '0;
            step_d  = (step == 3'(SPIN_STEPS - 1)) ? 3'd0 : step + 3'd1;
            phase_d = ~phase;
            count_d = count + 4'd1;
        end
        if (reload) begin
            count_d = bus.disp_val;
        end
    end

    // The glyph sees the restarted/reloaded state in the same cycle, so a
    // mode entry never flashes a stale frame.
    assign count_e = reload ? bus.disp_val : count;

    always_comb begin
        glyph = 7'h00;
        case (mode)
            ANIM_STATIC: glyph = hex_to_seg(bus.disp_val);
`ifdef BREATHE_EN
            ANIM_BLINK:  glyph = hex_to_seg(bus.disp_val);
`else
            ANIM_BLINK:  glyph = (phase && !restart) ? 7'h00 : hex_to_seg(bus.disp_val);
`endif
            ANIM_SPIN:   glyph = spin_to_seg(restart ? 3'd0 : step);
            ANIM_COUNT:  glyph = hex_to_seg(count_e);
            default:     glyph = 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anim_q <= ANIM_STATIC;
            disp_q <= 4'd0;
            presc  <= '0;
            step   <= 3'd0;
            phase  <= 1'b0;
            count  <= 4'd0;
            hb     <= 1'b0;
            seg_q  <= 7'h00;
            dp_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            anim_q <= mode;
            disp_q <= bus.disp_val;
            presc  <= presc_d;
            step   <= step_d;
            phase  <= phase_d;
            count  <= count_d;
            hb     <= hb ^ tick;
            seg_q  <= glyph & {7{pwm_on}};
            dp_q   <= hb & pwm_on;
            tick_q <= tick;
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.dp_out   = dp_q;
    assign bus.tick_out = tick_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed scenarios plus random
// input sequences, every cycle compared against an arithmetic reference.
module tb_seg_display_ctrl;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_display_ctrl_if bus ();

    seg_display_ctrl #(.TICK_DIV(TD), .TICK_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: elapsed cycles since reset and since the last mode
    // restart, total ticks seen, and the COUNT base with its tick offset.
    int         m_r = 0, m_e = 0, m_total = 0, m_base = 0, m_base_ticks = 0;
    logic [1:0] m_prev_anim = 2'd0;
    logic [3:0] m_prev_disp = 4'd0;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int tri_lvl(input int k, input int d);
        int m;
        if (d == 0) return 0;
        m = k % (2 * d);
        return (m <= d) ? m : 2 * d - m;
    endfunction

    // One clock: predict from the present inputs, clock, compare, advance.
    task automatic step_cycle();
        logic [6:0] g, exp_seg;
        logic       exp_dp, exp_tk, chg, reload, pon;
        int         ticks, cnt, lvl;
        g = 7'h00;
        chg = 1'b0;
        reload = 1'b0;
        exp_tk = 1'b0;
        if (!rst_n) begin
            exp_seg = 7'h00;
            exp_dp  = 1'b0;
        end else begin
            chg    = (bus.anim != m_prev_anim);
            ticks  = chg ? 0 : m_e / TD;
            exp_tk = !chg && (m_e % TD == TD - 1);
            reload = chg || (bus.anim == 2'd3 && bus.disp_val != m_prev_disp);
            cnt    = reload ? int'(bus.disp_val) : (m_base + ticks - m_base_ticks) % 16;
            lvl    = int'(bus.duty);
            case (bus.anim)
                2'd0: g = hex_tab[bus.disp_val];
`ifdef BREATHE_EN
                2'd1: begin
                    g   = hex_tab[bus.disp_val];
                    lvl = tri_lvl(ticks, int'(bus.duty));
                end
`else
                2'd1: g = (ticks % 2 == 1) ? 7'h00 : hex_tab[bus.disp_val];
`endif
                2'd2: g = 7'(1 << (ticks % 6));
                default: g = hex_tab[cnt[3:0]];
            endcase
            pon     = (lvl == 15) || ((m_r % 16) < lvl);
            exp_seg = pon ? g : 7'h00;
            exp_dp  = pon && (m_total % 2 == 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("seg_out", {25'd0, bus.seg_out}, {25'd0, exp_seg});
        check("dp_out", {31'd0, bus.dp_out}, {31'd0, exp_dp});
        check("tick_out", {31'd0, bus.tick_out}, {31'd0, exp_tk});
        if (!rst_n) begin
            m_r = 0; m_e = 0; m_total = 0; m_base = 0; m_base_ticks = 0;
            m_prev_anim = 2'd0;
            m_prev_disp = 4'd0;
        end else begin
            m_e = chg ? 0 : m_e + 1;
            if (reload) begin
                m_base       = int'(bus.disp_val);
                m_base_ticks = m_e / TD;
            end
            if (exp_tk) m_total++;
            m_r++;
            m_prev_anim = bus.anim;
            m_prev_disp = bus.disp_val;
        end
    endtask

    initial begin
        logic [6:0] seen [$];
        logic [6:0] last;
        int         on_cnt, off_cnt, tk_cnt, k;
        bit         found;

        // Reset held with SPIN selected at full brightness.
        bus.duty = 4'hF; bus.disp_val = 4'h0; bus.anim = 2'd2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step_cycle();
        check("reset_seg", {25'd0, bus.seg_out}, 32'h0);
        rst_n = 1'b1;

        // SPIN from release: first frame a, then a..f..a, tick every 4.
        step_cycle();
        check("spin_first", {25'd0, bus.seg_out}, 32'h01);
        seen.delete();
        seen.push_back(bus.seg_out);
        last = bus.seg_out;
        tk_cnt = 0;
        for (int i = 0; i < 28; i++) begin
            step_cycle();
            if (i < 16 && bus.tick_out) tk_cnt++;
            if (bus.seg_out != last) seen.push_back(bus.seg_out);
            last = bus.seg_out;
        end
        check("spin_ticks_16cyc", tk_cnt, 4);
        check("spin_frames", seen.size(), 7);
        if (seen.size() == 7) begin
            check("spin_f1", {25'd0, seen[1]}, 32'h02);
            check("spin_f5", {25'd0, seen[5]}, 32'h20);
            check("spin_wrap", {25'd0, seen[6]}, 32'h01);
        end

        // STATIC glyph and single-cycle update latency.
        bus.anim = 2'd0; bus.disp_val = 4'hA;
        step_cycle(); step_cycle();
        check("static_A", {25'd0, bus.seg_out}, 32'h77);
        bus.disp_val = 4'h5;
        step_cycle();
        check("static_5", {25'd0, bus.seg_out}, 32'h6D);

        // PWM: duty 4 is on 4 of 16 cycles, duty 0 is dark.
        bus.duty = 4'd4; bus.disp_val = 4'h8;
        step_cycle(); step_cycle();
        on_cnt = 0; off_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step_cycle();
            if (bus.seg_out == 7'h7F) on_cnt++;
            if (bus.seg_out == 7'h00) off_cnt++;
        end
        check("pwm_on_cnt", on_cnt, 4);
        check("pwm_off_cnt", off_cnt, 12);
        bus.duty = 4'd0;
        on_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step_cycle();
            if (bus.seg_out != 7'h00) on_cnt++;
        end
        check("pwm_duty0", on_cnt, 0);

        // COUNT from E, wrapping, then a mid-sequence reload to 5.
        bus.duty = 4'hF; bus.anim = 2'd3; bus.disp_val = 4'hE;
        seen.delete();
        last = 7'h00;
        for (int i = 0; i < 14; i++) begin
            step_cycle();
            if (bus.seg_out != last) seen.push_back(bus.seg_out);
            last = bus.seg_out;
        end
        check("count_frames", seen.size(), 4);
        if (seen.size() == 4) begin
            check("count_E", {25'd0, seen[0]}, 32'h79);
            check("count_F", {25'd0, seen[1]}, 32'h71);
            check("count_0", {25'd0, seen[2]}, 32'h3F);
            check("count_1", {25'd0, seen[3]}, 32'h06);
        end
        bus.disp_val = 4'h5;
        step_cycle();
        check("count_reload", {25'd0, bus.seg_out}, 32'h6D);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step_cycle();
            found = (bus.seg_out == 7'h7D);
        end
        check("count_after_reload", {31'd0, found}, 32'd1);

`ifdef BREATHE_EN
        // Breathe ramp at duty 8 over several full up/down sweeps.
        bus.anim = 2'd1; bus.disp_val = 4'h3; bus.duty = 4'd8;
        for (int i = 0; i < 160; i++) step_cycle();
        bus.anim = 2'd0;
        step_cycle();
        check("breathe_exit_static", {25'd0, bus.seg_out}, 32'h4F);
`else
        // BLINK starts visible, blanks, and a switch to STATIC restarts.
        bus.anim = 2'd1; bus.disp_val = 4'h3;
        step_cycle();
        check("blink_entry", {25'd0, bus.seg_out}, 32'h4F);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step_cycle();
            found = (bus.seg_out == 7'h00);
        end
        check("blink_blank_seen", {31'd0, found}, 32'd1);
        bus.anim = 2'd0;
        step_cycle();
        check("restart_static", {25'd0, bus.seg_out}, 32'h4F);
        k = 0;
        found = 1'b0;
        for (int i = 1; i <= 8 && !found; i++) begin
            step_cycle();
            if (bus.tick_out) begin
                found = 1'b1;
                k = i;
            end
        end
        check("restart_tick_delay", k, 4);
`endif

        // Random segments, with occasional resets and disp_val edits.
        for (int s = 0; s < 70; s++) begin
            int len;
            rst_n        = ($urandom_range(0, 14) != 0);
            bus.duty     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            bus.disp_val = 4'($urandom_range(0, 15));
            bus.anim     = 2'($urandom_range(0, 3));
`ifdef BREATHE_EN
            if (bus.anim == 2'd1) bus.anim = 2'd2;
`endif
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 7) == 0) bus.disp_val = 4'($urandom_range(0, 15));
                step_cycle();
            end
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
